// File: rtl/lfsr_decrypt.sv
// LFSR stream decrypter: recovers start state and taps from the pad preamble at 64..127,
// writes the stripped plaintext to 0..60 and the recovered parameters to 61..63.
module lfsr_decrypt (
   input  logic       clk,
   input  logic       init,
   output logic [7:0] mem_raddr,
   input  logic [7:0] mem_rdata,
   output logic [7:0] mem_waddr,
   output logic [7:0] mem_wdata,
   output logic       mem_wen,
   output logic       done,
   output logic       fail
);

   localparam logic [7:0]  ENC_BASE   = 8'd64;
   localparam logic [7:0]  PT_BASE    = 8'd0;
   localparam logic [7:0]  PAD        = 8'h20;
   localparam int unsigned PRE_CHECK  = 7;
   localparam logic [5:0]  LAST_CHECK = 6'(PRE_CHECK - 1);
   localparam logic [5:0]  PT_LEN     = 6'd61;
   localparam logic [7:0]  PARAM_BASE = 8'd61;

   localparam logic [2:0] StLoad    = 3'd0;
   localparam logic [2:0] StSearch  = 3'd1;
   localparam logic [2:0] StDecrypt = 3'd2;
   localparam logic [2:0] StFill    = 3'd3;
   localparam logic [2:0] StParams  = 3'd4;
   localparam logic [2:0] StDone    = 3'd5;
   localparam logic [2:0] StFail    = 3'd6;

   function automatic logic [5:0] lfsr_next(input logic [5:0] s, input logic [5:0] taps);
      return {s[4:0], ^(s & taps)};
   endfunction

   function automatic logic [5:0] tap_rom(input logic [3:0] idx);
      case (idx)
         4'd0:    return 6'h21;
         4'd1:    return 6'h2D;
         4'd2:    return 6'h30;
         4'd3:    return 6'h33;
         4'd4:    return 6'h36;
         4'd5:    return 6'h39;
         4'd6:    return 6'h3C;
         4'd7:    return 6'h3E;
         default: return 6'h3F;
      endcase
   endfunction

   logic [2:0] state_q, state_d;
   logic [5:0] start_q, start_d;
   logic [5:0] taps_q, taps_d;
   logic [5:0] s_q, s_d;
   logic [3:0] t_q, t_d;
   logic [5:0] i_q, i_d;
   logic [5:0] w_q, w_d;
   logic [6:0] prelen_q, prelen_d;
   logic       strip_q, strip_d;
   logic [1:0] pidx_q, pidx_d;

   logic [5:0] cand_taps;
   logic [5:0] s_next_search;
   logic [5:0] s_next_dec;
   logic [7:0] plain;

   always_comb begin
      state_d   = state_q;
      start_d   = start_q;
      taps_d    = taps_q;
      s_d       = s_q;
      t_d       = t_q;
      i_d       = i_q;
      w_d       = w_q;
      prelen_d  = prelen_q;
      strip_d   = strip_q;
      pidx_d    = pidx_q;
      mem_raddr = ENC_BASE;
      mem_waddr = PT_BASE;
      mem_wdata = 8'h00;
      mem_wen   = 1'b0;
      done      = 1'b0;
      fail      = 1'b0;

      cand_taps     = tap_rom(t_q);
      s_next_search = lfsr_next(s_q, cand_taps);
      s_next_dec    = lfsr_next(s_q, taps_q);
      plain         = mem_rdata ^ {2'b00, s_q};

      case (state_q)
         StLoad: begin
            start_d = mem_rdata[5:0] ^ PAD[5:0];
            s_d     = mem_rdata[5:0] ^ PAD[5:0];
            t_d     = 4'd0;
            i_d     = 6'd1;
            state_d = StSearch;
         end
         StSearch: begin
            mem_raddr = ENC_BASE + {2'b00, i_q};
            if (mem_rdata == (PAD ^ {2'b00, s_next_search})) begin
               if (i_q == LAST_CHECK) begin
                  taps_d   = cand_taps;
                  s_d      = start_q;
                  i_d      = 6'd0;
                  w_d      = 6'd0;
                  prelen_d = 7'd0;
                  strip_d  = 1'b1;
                  state_d  = StDecrypt;
               end else begin
                  s_d = s_next_search;
                  i_d = i_q + 6'd1;
               end
            end else if (t_q == 4'd8) begin
               state_d = StFail;
            end else begin
               // Next candidate restarts on the following cycle, no bubble.
               t_d = t_q + 4'd1;
               i_d = 6'd1;
               s_d = start_q;
            end
         end
         StDecrypt: begin
            mem_raddr = ENC_BASE + {2'b00, i_q};
            s_d       = s_next_dec;
            i_d       = i_q + 6'd1;
            if (strip_q && plain == PAD) begin
               if (prelen_q != 7'd64) prelen_d = prelen_q + 7'd1;
            end else begin
               strip_d   = 1'b0;
               mem_wen   = 1'b1;
               mem_waddr = PT_BASE + {2'b00, w_q};
               mem_wdata = plain;
               w_d       = w_q + 6'd1;
            end
            if (i_q == 6'd63) begin
               pidx_d  = 2'd0;
               state_d = (w_d < PT_LEN) ? StFill : StParams;
            end
         end
         StFill: begin
            mem_wen   = 1'b1;
            mem_waddr = PT_BASE + {2'b00, w_q};
            mem_wdata = PAD;
            w_d       = w_q + 6'd1;
            if (w_q == PT_LEN - 6'd1) state_d = StParams;
         end
         StParams: begin
            mem_wen   = 1'b1;
            mem_waddr = PARAM_BASE + {6'b0, pidx_q};
            case (pidx_q)
               2'd0:    mem_wdata = {1'b0, prelen_q};
               2'd1:    mem_wdata = {2'b00, taps_q};
               default: mem_wdata = {2'b00, start_q};
            endcase
            pidx_d = pidx_q + 2'd1;
            if (pidx_q == 2'd2) state_d = StDone;
         end
         StDone: begin
            done = 1'b1;
         end
         StFail: begin
            done = 1'b1;
            fail = 1'b1;
         end
         default: begin
            state_d = StLoad;
         end
      endcase

      // init forces idle outputs immediately so nothing commits at the restart edge.
      if (init) begin
         mem_raddr = ENC_BASE;
         mem_waddr = PT_BASE;
         mem_wdata = 8'h00;
         mem_wen   = 1'b0;
         done      = 1'b0;
         fail      = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (init) begin
         state_q  <= StLoad;
         start_q  <= 6'd0;
         taps_q   <= 6'd0;
         s_q      <= 6'd0;
         t_q      <= 4'd0;
         i_q      <= 6'd0;
         w_q      <= 6'd0;
         prelen_q <= 7'd0;
         strip_q  <= 1'b0;
         pidx_q   <= 2'd0;
      end else begin
         state_q  <= state_d;
         start_q  <= start_d;
         taps_q   <= taps_d;
         s_q      <= s_d;
         t_q      <= t_d;
         i_q      <= i_d;
         w_q      <= w_d;
         prelen_q <= prelen_d;
         strip_q  <= strip_d;
         pidx_q   <= pidx_d;
      end
   end

endmodule
